uart_tx_arbiter: RTL and testbench

// - Round-robin scheduler sharing one UART word transmitter among NREQ requesters.
// - Downstream is the UART top-level word interface (i_tx_data/i_tx_stb/i_tx_meta/o_tx_busy).
// - Grants one 16-bit word at a time, strobes it out, then waits for the transmitter to go busy and then idle.
// - Then it grants the next requester in rotating order.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_tx_arbiter_rr.sv | 36 +++
 rtl/uart_tx_arbiter.sv | 127 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Purpose : shared widths and FSM state encoding for the UART word-transmit arbiter.
// Latency : n/a (declarations only).
// Backpressure: n/a.
// Contents: UART_WORD_W, UART_META_W, GRANT_ID_W, arb_state_t.
package uart_pkg;

   localparam int UART_WORD_W = 16;
   localparam int UART_META_W = 2;
   localparam int GRANT_ID_W  = 3;   // wide enough for up to 8 requesters

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ISSUE    = 3'd1,
      ST_WAIT_ACK = 3'd2,
      ST_DRAIN    = 3'd3,
      ST_GAP      = 3'd4
   } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// Purpose : combinational rotating-priority picker; searches ptr+1, ptr+2, ... (mod NREQ).
// Latency : 0 cycles (pure combinational).
// Backpressure: none; the caller decides when to consume the grant.
// Ports   : req (request vector), ptr (last winner) -> grant (one-hot), idx (winner index), any (|req).
module rr_arbiter
   import uart_pkg::*;
#(
   parameter int NREQ = 4
) (
   input  logic [NREQ-1:0]       req,
   input  logic [GRANT_ID_W-1:0] ptr,
   output logic [NREQ-1:0]       grant,
   output logic [GRANT_ID_W-1:0] idx,
   output logic                  any
);

   always_comb begin
      int   j;
      logic found;
      j     = 0;
      found = 1'b0;
      grant = '0;
      idx   = '0;
      any   = |req;
      // k runs 1..NREQ so the previous winner is considered last.
      for (int k = 1; k <= NREQ; k++) begin
         j = (int'(ptr) + k) % NREQ;
         if (!found && req[j]) begin
            found    = 1'b1;
            grant[j] = 1'b1;
            idx      = GRANT_ID_W'(j);
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Purpose : round-robin sharing of one UART word transmitter among NREQ requesters.
// Latency : request seen in IDLE at cycle t -> o_tx_stb and req_ready pulse at t+1.
// Backpressure: no grant while i_tx_busy is high; each word waits for busy rise then fall (or ack timeout).
// Ports   : clk, rst (sync, active-high); req_valid/req_data/req_meta/req_ready requester side;
//           o_tx_data/o_tx_meta/o_tx_stb/i_tx_busy transmitter side; o_grant_id, o_active, o_err status.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NREQ       = 4,
   parameter int ACK_TO     = 4,
   parameter int GAP_CYCLES = 0
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NREQ-1:0]             req_valid,
   input  logic [UART_WORD_W*NREQ-1:0] req_data,
   input  logic [UART_META_W*NREQ-1:0] req_meta,
   output logic [NREQ-1:0]             req_ready,
   output logic [UART_WORD_W-1:0]      o_tx_data,
   output logic [UART_META_W-1:0]      o_tx_meta,
   output logic                        o_tx_stb,
   input  logic                        i_tx_busy,
   output logic [GRANT_ID_W-1:0]       o_grant_id,
   output logic                        o_active,
   output logic                        o_err
);

   localparam int ACK_W = $clog2(ACK_TO + 1);
   localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TO - 1);
   localparam logic [7:0]       GAP_LAST = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

   arb_state_t              state;
   logic [GRANT_ID_W-1:0]   ptr;
   logic [ACK_W-1:0]        ack_cnt;
   logic [7:0]              gap_cnt;

   logic [NREQ-1:0]         win_onehot;
   logic [GRANT_ID_W-1:0]   win_idx;
   logic                    win_any;
   logic [UART_WORD_W-1:0]  win_data;
   logic [UART_META_W-1:0]  win_meta;

   rr_arbiter #(.NREQ(NREQ)) u_rr (
      .req   (req_valid),
      .ptr   (ptr),
      .grant (win_onehot),
      .idx   (win_idx),
      .any   (win_any)
   );

   // Select the winner's word with constant slices.
   always_comb begin
      win_data = '0;
      win_meta = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (win_idx == GRANT_ID_W'(i)) begin
            win_data = req_data[UART_WORD_W*i +: UART_WORD_W];
            win_meta = req_meta[UART_META_W*i +: UART_META_W];
         end
      end
   end

   assign o_active = (state != ST_IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         ptr        <= GRANT_ID_W'(NREQ - 1);
         ack_cnt    <= '0;
         gap_cnt    <= '0;
         o_tx_data  <= '0;
         o_tx_meta  <= '0;
         o_tx_stb   <= 1'b0;
         req_ready  <= '0;
         o_grant_id <= '0;
         o_err      <= 1'b0;
      end else begin
         o_tx_stb  <= 1'b0;
         req_ready <= '0;
         o_err     <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (win_any && !i_tx_busy) begin
                  o_tx_data  <= win_data;
                  o_tx_meta  <= win_meta;
                  o_grant_id <= win_idx;
                  ptr        <= win_idx;
                  o_tx_stb   <= 1'b1;
                  req_ready  <= win_onehot;
                  state      <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               ack_cnt <= '0;
               state   <= ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
               if (i_tx_busy) begin
                  state <= ST_DRAIN;
               end else if (ack_cnt == ACK_LAST) begin
                  // Transmitter never took the word; report and move on.
                  o_err   <= 1'b1;
                  gap_cnt <= '0;
                  state   <= (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
               end else begin
                  ack_cnt <= ack_cnt + 1'b1;
               end
            end
            ST_DRAIN: begin
               if (!i_tx_busy) begin
                  gap_cnt <= '0;
                  state   <= (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
               end
            end
            ST_GAP: begin
               if (gap_cnt == GAP_LAST) begin
                  state <= ST_IDLE;
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Purpose : self-checking bench for uart_tx_arbiter (scoreboard of expected grants plus directed timing checks).
// Latency : n/a.
// Backpressure: transmitter model raises busy one cycle after each strobe for busy_len cycles.
module tb_uart_tx_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // ---------------- main DUT (GAP_CYCLES = 0) ----------------
   logic        rst;
   int          rem [4] = '{0, 0, 0, 0};
   logic [15:0] dat [4];
   logic [1:0]  mt  [4];
   logic [3:0]  req_valid;
   logic [63:0] req_data;
   logic [7:0]  req_meta;
   logic [3:0]  req_ready;
   logic [15:0] o_tx_data;
   logic [1:0]  o_tx_meta;
   logic        o_tx_stb;
   logic        mdl_busy;
   logic        force_busy;
   logic        i_tx_busy;
   logic [2:0]  o_grant_id;
   logic        o_active;
   logic        o_err;
   int          busy_len;

   assign i_tx_busy = mdl_busy | force_busy;

   always_comb begin
      req_valid = '0;
      req_data  = '0;
      req_meta  = '0;
      for (int i = 0; i < 4; i++) begin
         req_valid[i]         = (rem[i] != 0);
         req_data[16*i +: 16] = dat[i];
         req_meta[2*i +: 2]   = mt[i];
      end
   end

   uart_tx_arbiter #(.NREQ(4), .ACK_TO(4), .GAP_CYCLES(0)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_meta   (req_meta),
      .req_ready  (req_ready),
      .o_tx_data  (o_tx_data),
      .o_tx_meta  (o_tx_meta),
      .o_tx_stb   (o_tx_stb),
      .i_tx_busy  (i_tx_busy),
      .o_grant_id (o_grant_id),
      .o_active   (o_active),
      .o_err      (o_err)
   );

   // ---------------- second DUT (GAP_CYCLES = 3) ----------------
   logic        g_rst;
   logic [3:0]  g_valid;
   logic [63:0] g_data;
   logic [7:0]  g_meta;
   logic [3:0]  g_ready;
   logic [15:0] g_tx_data;
   logic [1:0]  g_tx_meta;
   logic        g_stb;
   logic        g_busy;
   logic [2:0]  g_gid;
   logic        g_active;
   logic        g_err;

   uart_tx_arbiter #(.NREQ(4), .ACK_TO(4), .GAP_CYCLES(3)) dut_g (
      .clk        (clk),
      .rst        (g_rst),
      .req_valid  (g_valid),
      .req_data   (g_data),
      .req_meta   (g_meta),
      .req_ready  (g_ready),
      .o_tx_data  (g_tx_data),
      .o_tx_meta  (g_tx_meta),
      .o_tx_stb   (g_stb),
      .i_tx_busy  (g_busy),
      .o_grant_id (g_gid),
      .o_active   (g_active),
      .o_err      (g_err)
   );

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic bound_fail(input string name, input int n, input int budget);
      checks++;
      if (n >= budget) begin
         failures++;
         $display("FAIL %s timeout actual=%0d cycles required<%0d", name, n, budget);
      end
   endtask

   typedef struct {
      logic [2:0]  id;
      logic [15:0] d;
      logic [1:0]  m;
   } exp_t;
   exp_t sb[$];

   task automatic push(input logic [2:0] id, input logic [15:0] d, input logic [1:0] m);
      exp_t e;
      e.id = id; e.d = d; e.m = m;
      sb.push_back(e);
   endtask

   // Monitor: every strobe or ready pulse must match the oldest expected grant.
   initial begin
      forever begin
         @(negedge clk);
         if (rst === 1'b0 && (o_tx_stb !== 1'b0 || req_ready !== 4'b0000)) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_grant actual stb=%b ready=%b id=%0d required no grant",
                        o_tx_stb, req_ready, o_grant_id);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("sb_stb",       {63'd0, o_tx_stb}, 64'd1);
               chk("sb_grant_id",  {61'd0, o_grant_id}, {61'd0, e.id});
               chk("sb_tx_data",   {48'd0, o_tx_data}, {48'd0, e.d});
               chk("sb_tx_meta",   {62'd0, o_tx_meta}, {62'd0, e.m});
               chk("sb_ready_1hot",{60'd0, req_ready}, {60'd0, 4'b0001 << e.id});
            end
         end
      end
   end

   // Requesters: on acceptance load the next word (data+1) and count down.
   initial begin
      forever begin
         @(negedge clk);
         for (int i = 0; i < 4; i++) begin
            if (req_ready[i] === 1'b1 && rem[i] > 0) begin
               rem[i] = rem[i] - 1;
               dat[i] = dat[i] + 16'd1;
            end
         end
      end
   end

   // Transmitter model: busy from the cycle after the strobe, for busy_len cycles.
   initial begin
      mdl_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (o_tx_stb === 1'b1 && busy_len > 0) begin
            @(posedge clk); #1 mdl_busy = 1'b1;
            repeat (busy_len) @(posedge clk);
            #1 mdl_busy = 1'b0;
         end
      end
   end

   task automatic wait_idle(input string name, input int budget);
      int n = 0;
      while (!(o_active === 1'b0 && mdl_busy === 1'b0 && sb.size() == 0 &&
               rem[0] == 0 && rem[1] == 0 && rem[2] == 0 && rem[3] == 0) && n < budget) begin
         @(negedge clk);
         n++;
      end
      bound_fail(name, n, budget);
   endtask

   task automatic wait_stb(input string name, input int budget);
      int n = 0;
      while (o_tx_stb !== 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      bound_fail(name, n, budget);
   endtask

   task automatic wait_busy(input logic lvl, input string name, input int budget);
      int n = 0;
      while (mdl_busy !== lvl && n < budget) begin
         @(negedge clk);
         n++;
      end
      bound_fail(name, n, budget);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      int n;
      rst = 1'b1; g_rst = 1'b1;
      force_busy = 1'b0; busy_len = 3;
      g_valid = '0; g_data = '0; g_meta = '0; g_busy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         dat[i] = 16'h1000 * 16'(i + 1);
         mt[i]  = 2'(i);
         rem[i] = 1;
      end
      // Reset with all requesters valid; grants afterwards run 0,1,2,3.
      push(3'd0, 16'h1000, 2'd0);
      push(3'd1, 16'h2000, 2'd1);
      push(3'd2, 16'h3000, 2'd2);
      push(3'd3, 16'h4000, 2'd3);
      for (int c = 0; c < 2; c++) begin
         @(posedge clk); @(negedge clk);
         chk("reset_hold", {36'd0, o_tx_stb, req_ready, o_tx_data, o_tx_meta, o_grant_id, o_active, o_err}, 64'd0);
      end
      @(posedge clk); #1 rst = 1'b0; g_rst = 1'b0;
      @(negedge clk);
      chk("reset_release", {36'd0, o_tx_stb, req_ready, o_tx_data, o_tx_meta, o_grant_id, o_active, o_err}, 64'd0);
      @(negedge clk);
      chk("first_stb_id0", {60'd0, o_tx_stb, o_grant_id}, {60'd0, 1'b1, 3'd0});
      wait_idle("t1_done", 200);

      // Round robin, all continuously valid: 0,1,2,3,0,1.
      @(posedge clk); #1;
      dat[0] = 16'h1100; dat[1] = 16'h2100; dat[2] = 16'h3100; dat[3] = 16'h4100;
      mt[0] = 2'd3; mt[1] = 2'd2; mt[2] = 2'd1; mt[3] = 2'd0;
      push(3'd0, 16'h1100, 2'd3);
      push(3'd1, 16'h2100, 2'd2);
      push(3'd2, 16'h3100, 2'd1);
      push(3'd3, 16'h4100, 2'd0);
      push(3'd0, 16'h1101, 2'd3);
      push(3'd1, 16'h2101, 2'd2);
      rem[0] = 2; rem[1] = 2; rem[2] = 1; rem[3] = 1;
      wait_idle("t3_done", 400);

      // Single word from requester 2, long busy.
      busy_len = 40;
      @(posedge clk); #1;
      dat[2] = 16'hBEEF; mt[2] = 2'b01;
      push(3'd2, 16'hBEEF, 2'b01);
      rem[2] = 1;
      @(negedge clk);
      chk("t2_no_stb_in_idle", {63'd0, o_tx_stb}, 64'd0);
      @(negedge clk);
      chk("t2_stb_latency", {59'd0, o_tx_stb, req_ready}, {59'd0, 1'b1, 4'b0100});
      wait_busy(1'b1, "t2_busy_rise", 10);
      wait_busy(1'b0, "t2_busy_fall", 60);
      chk("t2_active_drain", {63'd0, o_active}, 64'd1);
      @(negedge clk);
      chk("t2_active_low", {63'd0, o_active}, 64'd0);
      chk("t2_data_hold", {46'd0, o_tx_data, o_tx_meta}, {46'd0, 16'hBEEF, 2'b01});
      wait_idle("t2_done", 100);

      // Busy on arrival: no strobe until busy drops, then strobe one cycle later.
      busy_len = 2;
      @(posedge clk); #1;
      force_busy = 1'b1;
      dat[0] = 16'h5A5A; mt[0] = 2'd2;
      push(3'd0, 16'h5A5A, 2'd2);
      rem[0] = 1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         chk("t4_busy_hold", {63'd0, o_tx_stb}, 64'd0);
      end
      @(posedge clk); #1 force_busy = 1'b0;
      @(negedge clk);
      chk("t4_release_cycle", {63'd0, o_tx_stb}, 64'd0);
      @(negedge clk);
      chk("t4_stb_after_busy", {63'd0, o_tx_stb}, 64'd1);
      wait_idle("t4_done", 100);

      // Ack timeout: transmitter never goes busy.
      busy_len = 0;
      @(posedge clk); #1;
      dat[1] = 16'hC001; mt[1] = 2'd3;
      dat[2] = 16'hC002; mt[2] = 2'd0;
      push(3'd1, 16'hC001, 2'd3);
      push(3'd2, 16'hC002, 2'd0);
      rem[1] = 1; rem[2] = 1;
      wait_stb("t5_first_stb", 20);
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         chk("t5_err_early", {63'd0, o_err}, 64'd0);
      end
      @(negedge clk);
      chk("t5_err_pulse", {63'd0, o_err}, 64'd1);
      @(negedge clk);
      chk("t5_err_single_next_stb", {62'd0, o_err, o_tx_stb}, {62'd0, 1'b0, 1'b1});
      wait_idle("t5_done", 100);

      // GAP_CYCLES=3 instance: spacing after busy falls, then reset during DRAIN.
      @(posedge clk); #1;
      g_valid = 4'b0100; g_data[47:32] = 16'hC0DE; g_meta[5:4] = 2'b10;
      n = 0;
      while (g_stb !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      bound_fail("t6_first_stb", n, 20);
      chk("t6_first_grant", {35'd0, g_gid, g_tx_data, g_tx_meta, g_ready},
          {35'd0, 3'd2, 16'hC0DE, 2'b10, 4'b0100});
      g_valid = 4'b0000;
      @(posedge clk); #1;
      g_busy = 1'b1;
      g_valid = 4'b0010; g_data[31:16] = 16'hD00D; g_meta[3:2] = 2'b01;
      repeat (5) @(posedge clk);
      #1 g_busy = 1'b0;
      n = 0;
      @(negedge clk);
      while (g_stb !== 1'b1 && n < 50) begin n++; @(negedge clk); end
      // Busy-low cycle seen by DRAIN, three GAP cycles, one IDLE cycle, then the strobe.
      chk("t6_gap_spacing", 64'(n), 64'd5);
      chk("t6_second_grant", {45'd0, g_gid, g_tx_data}, {45'd0, 3'd1, 16'hD00D});
      g_valid = 4'b0000;
      @(posedge clk); #1;
      g_busy = 1'b1;
      g_valid = 4'b0101; g_data[15:0] = 16'h0AAA; g_data[47:32] = 16'h2BBB;
      @(posedge clk); #1;
      @(posedge clk); #1 g_rst = 1'b1;
      @(negedge clk);
      chk("t6_in_drain", {63'd0, g_active}, 64'd1);
      @(posedge clk); #1 g_rst = 1'b0; g_busy = 1'b0;
      @(negedge clk);
      chk("t6_rst_mid_word", {36'd0, g_stb, g_ready, g_tx_data, g_tx_meta, g_gid, g_active, g_err}, 64'd0);
      @(negedge clk);
      chk("t6_ptr_reset", {40'd0, g_stb, g_gid, g_tx_data, g_ready},
          {40'd0, 1'b1, 3'd0, 16'h0AAA, 4'b0001});
      g_valid = 4'b0000;

      repeat (5) @(negedge clk);
      chk("sb_drained", 64'(sb.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
